// File: rtl/mkt_msg_pkg.sv
// Shared types for the market-message decoder: message payload, message type codes, FSM states.
package mkt_msg_pkg;

    localparam int unsigned MSG_W = 64;

    localparam logic [7:0] MSG_TYPE_ADD    = 8'h41;
    localparam logic [7:0] MSG_TYPE_DELETE = 8'h44;
    localparam logic [7:0] MSG_TYPE_MODIFY = 8'h4D;
    localparam logic [7:0] MSG_TYPE_TRADE  = 8'h54;

    // Field order matches the beat layout: price in bytes 7..4, type in byte 0.
    typedef struct packed {
        logic [31:0] price;
        logic [23:0] symbol_id;
        logic [7:0]  msg_type;
    } msg_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_DISCARD = 1'b1
    } dec_state_t;

    function automatic logic is_known_type(input logic [7:0] t);
        return (t == MSG_TYPE_ADD) || (t == MSG_TYPE_DELETE) ||
               (t == MSG_TYPE_MODIFY) || (t == MSG_TYPE_TRADE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered valid and a look-ahead full flag for registered back-pressure.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type T = logic [63:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic valid,
    output logic full_nxt_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && (count != FULL_CNT);
    assign do_pop     = pop && (count != '0);
    assign dout       = mem[rd_ptr];
    assign full_nxt_c = (count_nxt == FULL_CNT);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + ONE;
        end else if (!do_push && do_pop) begin
            count_nxt = count - ONE;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= PW'(wr_ptr + PW'(1));
            end
            if (do_pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            count <= count_nxt;
            valid <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/axis_msg_decoder.sv
// Decodes single-beat AXI-stream market messages into a message FIFO, dropping malformed packets.
// Optional DECODER_STATS_EN adds saturating msg_count / drop_count outputs.
module axis_msg_decoder
    import mkt_msg_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic [WIDTH/8-1:0] s_axis_tkeep,
    output logic               m_msg_valid,
    input  logic               m_msg_ready,
    output logic [7:0]         m_msg_type,
    output logic [23:0]        m_symbol_id,
    output logic [31:0]        m_price,
    output logic               err_pulse
`ifdef DECODER_STATS_EN
    ,
    output logic [31:0]        msg_count,
    output logic [15:0]        drop_count
`endif
);

    dec_state_t state;
    dec_state_t state_nxt;
    logic       beat_acc;
    logic       push_c;
    logic       drop_err_c;
    logic       full_nxt_c;
    msg_t       beat_msg;
    msg_t       head;

    assign beat_acc = s_axis_tvalid && s_axis_tready;
    assign beat_msg = msg_t'(s_axis_tdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (beat_acc && !s_axis_tlast) state_nxt = ST_DISCARD;
            ST_DISCARD: if (beat_acc && s_axis_tlast)  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Only IDLE starts packets; the rest of a multi-beat packet is silently swallowed.
    always_comb begin
        push_c     = 1'b0;
        drop_err_c = 1'b0;
        if (state == ST_IDLE && beat_acc) begin
            if (s_axis_tlast && (s_axis_tkeep == '1) && is_known_type(beat_msg.msg_type)) begin
                push_c = 1'b1;
            end else begin
                drop_err_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            s_axis_tready <= (state_nxt == ST_DISCARD) || !full_nxt_c;
            err_pulse     <= drop_err_c;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (msg_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_c),
        .din        (beat_msg),
        .pop        (m_msg_ready),
        .dout       (head),
        .valid      (m_msg_valid),
        .full_nxt_c (full_nxt_c)
    );

    assign m_msg_type  = head.msg_type;
    assign m_symbol_id = head.symbol_id;
    assign m_price     = head.price;

`ifdef DECODER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push_c && (msg_count != '1)) begin
                msg_count <= msg_count + 32'd1;
            end
            if (drop_err_c && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/axis_msg_decoder.md
AXIS_MSG_DECODER -- requirements
Module: axis_msg_decoder

Interface
REQ-001 DEPTH, 4, output message FIFO depth in entries; SHALL be a power of two, 2..16.
REQ-002 WIDTH, 64, AXI-stream data width; only 64 SHALL be supported.
REQ-003 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata  in  64  inbound beat.
REQ-006 s_axis_tvalid  in  1  beat valid.
REQ-007 s_axis_tready  out  1  decoder can accept a beat.
REQ-008 s_axis_tlast  in  1  last beat of packet.
REQ-009 s_axis_tkeep  in  8  byte enables.
REQ-010 m_msg_valid  out  1  decoded message available at FIFO head.
REQ-011 m_msg_ready  in  1  downstream accepts head message.
REQ-012 m_msg_type  out  8  message type.
REQ-013 m_symbol_id  out  24  symbol identifier.
REQ-014 m_price  out  32  signed Q16.16 price.
REQ-015 err_pulse  out  1  one-cycle pulse per dropped packet.

Function
REQ-016 Byte n SHALL be tdata[8n+7:8n]; msg_type=tdata[7:0], symbol_id=tdata[31:8], price=tdata[63:32].
REQ-017 A beat SHALL be accepted only when s_axis_tvalid and s_axis_tready are both high on a rising edge.
REQ-018 s_axis_tready SHALL be high when FIFO is not full or FSM is DISCARD, low otherwise; it SHALL be low during reset.
REQ-019 FSM states: IDLE and DISCARD; reset state SHALL be IDLE.
REQ-020 In IDLE, an accepted beat with tlast=1, tkeep=8'hFF and msg_type in {0x41,0x44,0x4D,0x54} SHALL be pushed to the FIFO.
REQ-021 In IDLE, an accepted beat with tlast=1 failing the tkeep or msg_type check SHALL be dropped and pulse err_pulse the next cycle.
REQ-022 In IDLE, an accepted beat with tlast=0 SHALL be dropped, pulse err_pulse the next cycle, and move the FSM to DISCARD.
REQ-023 In DISCARD, every accepted beat SHALL be dropped without err_pulse; a beat with tlast=1 SHALL return the FSM to IDLE.
REQ-024 Latency: a pushed beat SHALL appear on m_msg_valid and the field outputs one cycle after acceptance when the FIFO was empty.
REQ-025 The head SHALL pop when m_msg_valid and m_msg_ready are both high; field outputs SHALL hold stable while m_msg_valid is high and m_msg_ready is low.
REQ-026 A simultaneous push and pop SHALL leave the occupancy unchanged; when full, a pop SHALL raise s_axis_tready the next cycle, not the same cycle.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a count of $clog2(DEPTH)+1 bits.
REQ-028 Messages SHALL leave in arrival order with no loss and no duplication.

Reset
REQ-029 On rst, the FIFO SHALL be emptied; m_msg_valid, err_pulse and s_axis_tready SHALL be 0; the field outputs SHALL be 0; FSM SHALL go to IDLE; counters SHALL be 0.
REQ-030 Reset asserted mid-packet or with the FIFO full SHALL discard all held state; the first beat after reset SHALL be treated as a packet start.

Configuration
REQ-031 When DECODER_STATS_EN is defined, the block SHALL add outputs msg_count (out, 32), incremented per push, and drop_count (out, 16), incremented per err_pulse; both SHALL saturate at all-ones.
REQ-032 When DECODER_STATS_EN is undefined, these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package mkt_msg_pkg SHALL hold the msg_t packed struct (price, symbol_id, msg_type), the four msg_type localparams and the decoder state enum.
REQ-034 Storage SHALL be a sub-module sync_fifo, parameterised by DEPTH and element type msg_t.

Verification
REQ-035 Valid beat tdata=64'h00640000_00012341, tkeep=FF, tlast=1 -> next cycle m_msg_valid=1, type 0x41, symbol 0x000123, price 0x00640000.
REQ-036 Beat with type 0x99 -> no push; err_pulse=1 for one cycle; drop_count=1 when stats are enabled.
REQ-037 Three-beat packet with tlast on beat 3, followed by a valid 0x54 beat -> one err_pulse, and only the 0x54 message is output.
REQ-038 m_msg_ready=0 with 5 valid beats offered at DEPTH=4 -> 4 beats accepted and tready=0; one pop -> tready=1 the next cycle; order preserved.
REQ-039 Continuous valid traffic with m_msg_ready=1 -> one message per cycle at full throughput, and the FIFO never fills.
REQ-040 rst pulsed while the FIFO holds 3 messages and the FSM is in DISCARD -> all outputs are 0 and the next valid beat decodes normally.
